// File: rtl/lsab_turn_scheduler.sv
// Round-robin owner of the single LSAB transfer port across four peripheral channels.
// Issues turn/turn_vld, counts word strobes against a per-channel burst, and releases on completion, withdrawal, disable or stall.
module lsab_turn_scheduler #(
   parameter int BURST_W = 8,
   parameter int TMO_W   = 6
) (
   input  logic                 CPU_CLK,
   input  logic                 RST,
   input  logic [3:0]           ch_en,
   input  logic [3:0]           req,
   input  logic [4*BURST_W-1:0] burst_len,
   input  logic                 word_stb,
   input  logic [3:0]           err_clr,
   output logic [1:0]           turn,
   output logic                 turn_vld,
   output logic [3:0]           grant,
   output logic [3:0]           done,
   output logic [3:0]           timeout_err,
   output logic [1:0]           state_dbg
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      GAP    = 2'd2
   } state_t;

   state_t             state;
   logic [1:0]         rr_ptr;
   logic [BURST_W-1:0] word_cnt;
   logic [TMO_W-1:0]   tmo_cnt;

   logic [3:0]         elig;
   logic [1:0]         winner;
   logic [BURST_W-1:0] win_len;
   logic [3:0]         turn_oh;
   logic               cur_live;
   logic [3:0]         err_set;

   assign state_dbg = state;

   always_comb begin
      elig    = req & ch_en;
      winner  = rr_ptr;
      // Walk from the farthest slot back to rr_ptr so the nearest eligible channel wins.
      for (int i = 3; i >= 0; i--) begin
         if (elig[rr_ptr + 2'(i)]) winner = rr_ptr + 2'(i);
      end
      win_len  = burst_len[winner*BURST_W +: BURST_W];
      turn_oh  = 4'b0001 << turn;
      cur_live = req[turn] & ch_en[turn];
      err_set  = '0;
      if (state == ACTIVE && cur_live && !word_stb && tmo_cnt == '1) err_set = turn_oh;
   end

   always_ff @(posedge CPU_CLK) begin
      if (!RST) begin
         state       <= IDLE;
         turn        <= '0;
         turn_vld    <= 1'b0;
         grant       <= '0;
         done        <= '0;
         timeout_err <= '0;
         rr_ptr      <= '0;
         word_cnt    <= '0;
         tmo_cnt     <= '0;
      end else begin
         done        <= '0;
         // A fresh timeout beats a same-cycle clear.
         timeout_err <= err_set | (timeout_err & ~err_clr);
         case (state)
            IDLE: begin
               if (|elig) begin
                  turn     <= winner;
                  turn_vld <= 1'b1;
                  grant    <= 4'b0001 << winner;
                  word_cnt <= win_len;
                  tmo_cnt  <= '0;
                  state    <= ACTIVE;
               end
            end
            ACTIVE: begin
               if (!cur_live) begin
                  turn_vld <= 1'b0;
                  grant    <= '0;
                  state    <= GAP;
               end else if (word_stb) begin
                  tmo_cnt <= '0;
                  if (word_cnt == BURST_W'(1)) begin
                     done     <= turn_oh;
                     turn_vld <= 1'b0;
                     grant    <= '0;
                     state    <= GAP;
                  end else begin
                     // A loaded zero wraps here, giving a full 2^BURST_W word burst.
                     word_cnt <= word_cnt - 1'b1;
                  end
               end else if (tmo_cnt == '1) begin
                  turn_vld <= 1'b0;
                  grant    <= '0;
                  state    <= GAP;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            GAP: begin
               rr_ptr <= turn + 2'd1;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsab_turn_scheduler.sv
// Directed bench for lsab_turn_scheduler: cycle vector table plus hand sequences
// for zero-length bursts, stall timeout and mid-burst reset.
module tb_lsab_turn_scheduler;

   logic        CPU_CLK = 1'b0;
   logic        RST = 1'b0;
   logic [3:0]  ch_en = '0;
   logic [3:0]  req = '0;
   logic [31:0] burst_len = '0;
   logic        word_stb = 1'b0;
   logic [3:0]  err_clr = '0;
   logic [1:0]  turn;
   logic        turn_vld;
   logic [3:0]  grant;
   logic [3:0]  done;
   logic [3:0]  timeout_err;
   logic [1:0]  state_dbg;

   int n_pass = 0;
   int n_total = 0;

   lsab_turn_scheduler #(.BURST_W(8), .TMO_W(6)) dut (
      .CPU_CLK     (CPU_CLK),
      .RST         (RST),
      .ch_en       (ch_en),
      .req         (req),
      .burst_len   (burst_len),
      .word_stb    (word_stb),
      .err_clr     (err_clr),
      .turn        (turn),
      .turn_vld    (turn_vld),
      .grant       (grant),
      .done        (done),
      .timeout_err (timeout_err),
      .state_dbg   (state_dbg)
   );

   always #5 CPU_CLK = ~CPU_CLK;

   typedef struct {
      logic        rst;
      logic [3:0]  en;
      logic [3:0]  rq;
      logic [31:0] len;
      logic        stb;
      logic [3:0]  clr;
      logic        vld;
      logic [1:0]  trn;
      logic [3:0]  gnt;
      logic [3:0]  dn;
      logic [3:0]  er;
      string       name;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Packed as {vld, turn, grant, done, timeout_err}.
   task automatic check_out(input string name, input logic vld, input logic [1:0] trn,
                            input logic [3:0] gnt, input logic [3:0] dn, input logic [3:0] er);
      check(name, {17'b0, turn_vld, turn, grant, done, timeout_err},
                  {17'b0, vld, trn, gnt, dn, er});
   endtask

   task automatic add(input logic rst, input logic [3:0] en, input logic [3:0] rq,
                      input logic [31:0] len, input logic stb, input logic [3:0] clr,
                      input logic vld, input logic [1:0] trn, input logic [3:0] gnt,
                      input logic [3:0] dn, input logic [3:0] er, input string name);
      vec_t v;
      v.rst = rst; v.en = en; v.rq = rq; v.len = len; v.stb = stb; v.clr = clr;
      v.vld = vld; v.trn = trn; v.gnt = gnt; v.dn = dn; v.er = er; v.name = name;
      tbl.push_back(v);
   endtask

   task automatic tick();
      @(posedge CPU_CLK);
      #1;
   endtask

   task automatic apply(input vec_t v);
      RST = v.rst; ch_en = v.en; req = v.rq; burst_len = v.len;
      word_stb = v.stb; err_clr = v.clr;
      tick();
      check_out(v.name, v.vld, v.trn, v.gnt, v.dn, v.er);
   endtask

   task automatic do_reset();
      RST = 1'b0; req = '0; word_stb = 1'b0; err_clr = '0;
      tick();
      tick();
      RST = 1'b1;
   endtask

   initial begin
      logic [1:0] ch;
      logic [3:0] oh;
      int early;
      int drops;

      // Single request on channel 0, burst of 4, then regrant while req stays high.
      add(0, 4'hF, 4'h0, 32'h4, 0, 0, 0, 0, 4'h0, 4'h0, 0, "a_reset");
      add(1, 4'hF, 4'h1, 32'h4, 0, 0, 1, 0, 4'h1, 4'h0, 0, "a_grant");
      add(1, 4'hF, 4'h1, 32'h4, 1, 0, 1, 0, 4'h1, 4'h0, 0, "a_w1");
      add(1, 4'hF, 4'h1, 32'h4, 1, 0, 1, 0, 4'h1, 4'h0, 0, "a_w2");
      add(1, 4'hF, 4'h1, 32'h4, 1, 0, 1, 0, 4'h1, 4'h0, 0, "a_w3");
      add(1, 4'hF, 4'h1, 32'h4, 1, 0, 0, 0, 4'h0, 4'h1, 0, "a_done");
      add(1, 4'hF, 4'h1, 32'h4, 1, 0, 0, 0, 4'h0, 4'h0, 0, "a_idle");
      add(1, 4'hF, 4'h1, 32'h4, 1, 0, 1, 0, 4'h1, 4'h0, 0, "a_regrant");

      // Round robin over all four channels with burst 2.
      add(0, 4'hF, 4'hF, 32'h02020202, 1, 0, 0, 0, 4'h0, 4'h0, 0, "rr_reset");
      for (int g = 0; g < 5; g++) begin
         ch = 2'(g % 4);
         oh = 4'b0001 << ch;
         add(1, 4'hF, 4'hF, 32'h02020202, 1, 0, 1, ch, oh, 4'h0, 0, $sformatf("rr_grant%0d", g));
         if (g < 4) begin
            add(1, 4'hF, 4'hF, 32'h02020202, 1, 0, 1, ch, oh, 4'h0, 0, $sformatf("rr_word%0d", g));
            add(1, 4'hF, 4'hF, 32'h02020202, 1, 0, 0, ch, 4'h0, oh, 0, $sformatf("rr_done%0d", g));
            add(1, 4'hF, 4'hF, 32'h02020202, 1, 0, 0, ch, 4'h0, 4'h0, 0, $sformatf("rr_idle%0d", g));
         end
      end

      // Channel 1 disabled, channel 0 burst 3, then withdrawal mid-burst.
      add(0, 4'hD, 4'h3, 32'h01010103, 1, 0, 0, 0, 4'h0, 4'h0, 0, "c_reset");
      add(1, 4'hD, 4'h3, 32'h01010103, 1, 0, 1, 0, 4'h1, 4'h0, 0, "c_grant");
      add(1, 4'hD, 4'h3, 32'h01010103, 1, 0, 1, 0, 4'h1, 4'h0, 0, "c_w1");
      add(1, 4'hD, 4'h3, 32'h01010103, 1, 0, 1, 0, 4'h1, 4'h0, 0, "c_w2");
      add(1, 4'hD, 4'h3, 32'h01010103, 1, 0, 0, 0, 4'h0, 4'h1, 0, "c_done");
      add(1, 4'hD, 4'h3, 32'h01010103, 1, 0, 0, 0, 4'h0, 4'h0, 0, "c_idle");
      add(1, 4'hD, 4'h3, 32'h01010103, 1, 0, 1, 0, 4'h1, 4'h0, 0, "c_skip_ch1");
      add(1, 4'hD, 4'h3, 32'h01010103, 1, 0, 1, 0, 4'h1, 4'h0, 0, "c_w1b");
      add(1, 4'hD, 4'h2, 32'h01010103, 1, 0, 0, 0, 4'h0, 4'h0, 0, "c_withdraw");
      add(1, 4'hD, 4'h2, 32'h01010103, 0, 0, 0, 0, 4'h0, 4'h0, 0, "c_gap_idle");
      add(1, 4'hD, 4'h2, 32'h01010103, 0, 0, 0, 0, 4'h0, 4'h0, 0, "c_ch1_never");

      foreach (tbl[i]) apply(tbl[i]);

      // Zero length means 256 words.
      do_reset();
      ch_en = 4'hF; burst_len = 32'h0; req = 4'b0100; word_stb = 1'b0;
      tick();
      check_out("z_grant", 1, 2, 4'b0100, 4'h0, 4'h0);
      word_stb = 1'b1;
      early = 0;
      drops = 0;
      for (int i = 1; i <= 255; i++) begin
         tick();
         if (done != 4'h0) early++;
         if (!turn_vld) drops++;
      end
      check("z_no_early_done", 32'(early), 32'd0);
      check("z_vld_held", 32'(drops), 32'd0);
      tick();
      check_out("z_done_256", 0, 2, 4'h0, 4'b0100, 4'h0);
      word_stb = 1'b0; req = 4'h0;

      // Stall timeout on channel 3, clear, and set-beats-clear.
      do_reset();
      ch_en = 4'hF; burst_len = 32'h04000000; req = 4'b1000;
      tick();
      check_out("t_grant", 1, 3, 4'b1000, 4'h0, 4'h0);
      repeat (63) tick();
      check_out("t_before", 1, 3, 4'b1000, 4'h0, 4'h0);
      tick();
      check_out("t_fire", 0, 3, 4'h0, 4'h0, 4'b1000);
      err_clr = 4'b1000;
      tick();
      err_clr = 4'h0;
      check_out("t_clear", 0, 3, 4'h0, 4'h0, 4'h0);
      tick();
      check_out("t_regrant", 1, 3, 4'b1000, 4'h0, 4'h0);
      repeat (63) tick();
      err_clr = 4'b1000;
      tick();
      err_clr = 4'h0;
      check_out("t_set_wins", 0, 3, 4'h0, 4'h0, 4'b1000);
      req = 4'h0;

      // Reset in the middle of a channel 2 burst with count 3.
      do_reset();
      ch_en = 4'hF; burst_len = 32'h00050100; req = 4'b0010; word_stb = 1'b1;
      tick();
      check_out("r_grant1", 1, 1, 4'b0010, 4'h0, 4'h0);
      tick();
      check_out("r_done1", 0, 1, 4'h0, 4'b0010, 4'h0);
      req = 4'b0100;
      tick();
      tick();
      check_out("r_grant2", 1, 2, 4'b0100, 4'h0, 4'h0);
      tick();
      tick();
      check_out("r_cnt3", 1, 2, 4'b0100, 4'h0, 4'h0);
      RST = 1'b0;
      tick();
      check_out("r_reset", 0, 0, 4'h0, 4'h0, 4'h0);
      check("r_state_idle", 32'(state_dbg), 32'd0);
      RST = 1'b1; req = 4'b0111; word_stb = 1'b0;
      tick();
      check_out("r_rr0", 1, 0, 4'b0001, 4'h0, 4'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/lsab_turn_scheduler.md
Name: lsab_turn_scheduler

Overview:
- Round-robin scheduler that shares one LSAB transfer port between four peripheral channels (Ethernet on channel 0, channels 1-3 spare).
- Issues the 2-bit LSAB turn plus a valid flag, and counts word strobes against a per-channel burst length.
- Releases the turn on burst completion, on request withdrawal, on channel disable, or on stall timeout.
- Sits between the peripheral request lines and the core's write_fifo_cr / read_fifo_cw turn inputs.

Parameters:
- BURST_W, 8, width of each per-channel burst length field and of the word counter.
- TMO_W, 6, stall-timeout counter width; timeout fires after 2^TMO_W (64) cycles with no word_stb.

Ports:
- CPU_CLK  input  1  clock; all logic on the rising edge.
- RST  input  1  synchronous, active-low reset.
- ch_en  input  4  per-channel enable; a disabled channel is never granted.
- req  input  4  per-channel transfer request, level-sensitive.
- burst_len  input  4*BURST_W  packed lengths, channel n at [n*BURST_W +: BURST_W]; value 0 means 2^BURST_W words.
- word_stb  input  1  one word moved on the LSAB by the granted channel.
- err_clr  input  4  per-channel clear for the timeout_err bits.
- turn  output  2  index of the granted channel.
- turn_vld  output  1  turn is valid; the LSAB may move words.
- grant  output  4  one-hot grant, equal to decode(turn) & {4{turn_vld}}.
- done  output  4  one-cycle pulse on burst completion for the granted channel.
- timeout_err  output  4  sticky stall-timeout flag per channel.

Behaviour:
- Reset (RST=0 at a clock edge):
  - state=IDLE; turn=0, turn_vld=0, grant=0, done=0, timeout_err=0.
  - rr_ptr=0, word count=0, timeout count=0.
  - Reset applied mid-grant aborts immediately: no done pulse, no error.
- States: IDLE, ACTIVE, GAP.
- IDLE:
  - elig = req & ch_en.
  - If elig is nonzero: winner = first set bit searching rr_ptr, rr_ptr+1, ... mod 4.
  - Register turn=winner and turn_vld=1; load word count = burst_len[winner] latched at this edge; clear timeout count; go to ACTIVE.
  - Latency: elig set in cycle k gives turn_vld=1 in cycle k+1.
- ACTIVE (evaluated at each edge in this priority order):
  1. req[turn]=0 or ch_en[turn]=0 -> GAP; no done pulse.
  2. word_stb=1 and count==1 -> done[turn]=1 for one cycle, GAP.
  3. word_stb=1 otherwise -> count-=1 (mod 2^BURST_W, so a loaded 0 counts 256 words); clear timeout count.
  4. word_stb=0 -> timeout count+=1; at all-ones go to GAP and set timeout_err[turn].
- Burst length changes during ACTIVE have no effect; the length is latched at grant.
- GAP:
  - Exactly one cycle with turn_vld=0; turn holds its last value.
  - rr_ptr = old turn+1 mod 4; go to IDLE.
  - This guarantees at least one dead cycle between grants.
- word_stb outside ACTIVE is ignored.
- timeout_err[n]:
  - Set has priority over clear in the same cycle.
  - err_clr[n] clears the bit on the next edge.
- Only one channel holds a grant at a time; grant is never multi-hot.
- Back-to-back grants: minimum period is burst + 2 cycles (ACTIVE words, GAP, IDLE arbitration).

Test Plan:
- Reset, single request:
  - Stimulus: release RST; ch_en=4'hF, req=4'b0001, burst_len[0]=4, one word_stb per cycle.
  - Response: turn_vld=1 one cycle after req. done[0] pulses on the 4th strobe. turn_vld=0 next cycle. Regrant two cycles after done while req stays high.
- Round robin:
  - Stimulus: req=4'b1111 held, all burst_len=2, continuous strobes.
  - Response: grant order 0,1,2,3,0; each grant lasts exactly 2 cycles with one GAP cycle between grants.
- Disabled and withdrawn channels:
  - Stimulus: ch_en=4'b1101, req=4'b0011.
  - Response: channel 1 is never granted.
  - Stimulus: drop req[0] mid-burst.
  - Response: GAP next cycle, done stays 0.
- Zero length:
  - Stimulus: burst_len[2]=0, req=4'b0100, strobes every cycle.
  - Response: done[2] pulses on the 256th strobe, not earlier.
- Timeout:
  - Stimulus: grant channel 3, no word_stb for 64 cycles.
  - Response: timeout_err[3]=1 and GAP.
  - Stimulus: err_clr[3]=1 for one cycle.
  - Response: bit clears.
  - Stimulus: err_clr asserted in the same cycle as a new timeout.
  - Response: bit stays set.
- Reset mid-operation:
  - Stimulus: RST=0 during ACTIVE with count=3.
  - Response: all outputs 0 next cycle, no done pulse. After release, the first grant follows rr_ptr=0 priority.
